// File: rtl/squarer_pkg.sv
// Shared types and sizes for the odd-number squarer.
// Holds the FSM state enum, operand width and square width.
package squarer_pkg;

  localparam int WIDTH    = 8;
  localparam int SQ_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/square_step_adder.sv
// Accumulate step of the squarer: sum = a + b.
// Ports: a, b (W bits) in; sum (W bits) out. No carry-in.
module square_step_adder
  import squarer_pkg::*;
#(
  parameter int W = SQ_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // The carry-out is dropped: the largest result, 255*255,
  // fits in W bits, so it can never be set.
  assign sum = a + b;

endmodule

// File: rtl/square_seq.sv
// Sequential squarer: N*N as the sum of the first N odd numbers.
// Ports: clk, rst (sync, high), start_i, valor_i in; square_o, ready_o, busy_o out.
module square_seq
  import squarer_pkg::*;
#(
  parameter int WIDTH = squarer_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   valor_i,
  output logic [2*WIDTH-1:0] square_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int SW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH:0]   k;
  logic [SW-1:0]    sq;
  logic [SW-1:0]    addend;
  logic [SW-1:0]    sq_next;
  logic             k_done;

  // Odd number 2k+1; k stays below N while adding, so its MSB is unused here.
  assign addend = {{(SW-WIDTH-1){1'b0}}, k[WIDTH-1:0], 1'b1};
  assign k_done = (k == {1'b0, n});

  square_step_adder #(
    .W (SW)
  ) u_add (
    .a   (sq),
    .b   (addend),
    .sum (sq_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n        <= '0;
      k        <= '0;
      sq       <= '0;
      square_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= CALC;
            n      <= valor_i;
            k      <= '0;
            sq     <= '0;
            busy_o <= 1'b1;
          end
        end
        CALC: begin
          if (k_done) begin
            square_o <= sq;
            ready_o  <= 1'b1;
            state    <= DONE;
          end else begin
            sq <= sq_next;
            k  <= k + {{WIDTH{1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_seq.sv
// Directed self-checking bench for square_seq.
// Edge 0 is the rising edge that samples start_i.
module tb_square_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  valor_i;
  logic [15:0] square_o;
  logic        ready_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  square_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .valor_i  (valor_i),
    .square_o (square_o),
    .ready_o  (ready_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready_o === 1'b1) pulses++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ends 1 time unit after edge 0.
  task automatic start_run(input logic [7:0] v);
    @(negedge clk);
    start_i = 1'b1;
    valor_i = v;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Steps edges first..first+limit; returns the edge where ready_o is seen.
  task automatic wait_ready(input int first, output int at,
                            output bit all_busy);
    bit found;
    found    = 1'b0;
    all_busy = 1'b1;
    at       = -1;
    for (int e = first; e <= first + 300; e++) begin
      if (!found) begin
        @(posedge clk);
        #1;
        if (busy_o !== 1'b1) all_busy = 1'b0;
        if (ready_o === 1'b1) begin
          at    = e;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  int  at;
  bit  ab;

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    valor_i = '0;
    step(3);
    chk("rst_square", square_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // N=0
    start_run(8'd0);
    chk("n0_busy_e0", busy_o, 1);
    wait_ready(1, at, ab);
    chk("n0_edge", at, 1);
    chk("n0_sq", square_o, 0);
    step(1);
    chk("n0_idle_busy", busy_o, 0);

    // N=12
    start_run(8'd12);
    chk("n12_busy_e0", busy_o, 1);
    wait_ready(1, at, ab);
    chk("n12_edge", at, 13);
    chk("n12_sq", square_o, 144);
    chk("n12_busy_all", ab, 1);
    step(1);
    chk("n12_pulse_end", ready_o, 0);
    chk("n12_busy_end", busy_o, 0);
    chk("n12_hold", square_o, 144);

    // N=255
    start_run(8'd255);
    wait_ready(1, at, ab);
    chk("n255_edge", at, 256);
    chk("n255_sq", square_o, 16'hFE01);
    step(2);

    // N=5 with a later operand change and an ignored second start
    pulses = 0;
    start_run(8'd5);
    step(1);
    valor_i = 8'd9;
    step(1);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    wait_ready(4, at, ab);
    chk("n5_edge", at, 6);
    chk("n5_sq", square_o, 25);
    step(20);
    chk("n5_pulses", pulses, 1);
    chk("n5_idle", busy_o, 0);

    // start while ready_o is high is ignored
    start_run(8'd2);
    wait_ready(1, at, ab);
    chk("n2_edge", at, 3);
    start_i = 1'b1;
    valor_i = 8'd4;
    step(1);
    start_i = 1'b0;
    chk("done_start_busy", busy_o, 0);
    step(10);
    chk("done_start_sq", square_o, 4);
    chk("done_start_idle", busy_o, 0);

    // reset mid-CALC aborts
    pulses = 0;
    start_run(8'd200);
    step(49);
    chk("abort_busy_pre", busy_o, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_sq", square_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", ready_o, 0);
    step(260);
    chk("abort_pulses", pulses, 0);
    start_run(8'd3);
    wait_ready(1, at, ab);
    chk("n3_edge", at, 4);
    chk("n3_sq", square_o, 9);
    step(2);

    // start together with rst is ignored
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b1;
    valor_i = 8'd6;
    step(1);
    rst     = 1'b0;
    start_i = 1'b0;
    chk("rst_start_busy", busy_o, 0);
    step(3);
    chk("rst_start_idle", busy_o, 0);

    // back-to-back N=7 then N=16
    start_run(8'd7);
    wait_ready(1, at, ab);
    chk("n7_edge", at, 8);
    chk("n7_sq", square_o, 49);
    step(1);
    chk("n7_ready_off", ready_o, 0);
    start_run(8'd16);
    step(5);
    chk("n7_held", square_o, 49);
    wait_ready(6, at, ab);
    chk("n16_edge", at, 17);
    chk("n16_sq", square_o, 256);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/square_seq.md
SQUARE_SEQ -- requirements
Module: square_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL expose: start_i  in  1  request pulse, sampled only in IDLE.
REQ-003 The block SHALL expose: valor_i  in  8  root operand N, sampled with start_i.
REQ-004 The block SHALL expose: square_o  out  16  result N*N, held stable until the next accepted start.
REQ-005 The block SHALL expose: ready_o  out  1  one-cycle pulse marking square_o valid.
REQ-006 The block SHALL expose: busy_o  out  1  high while in CALC or DONE.
REQ-007 The block SHALL take one parameter: WIDTH, default 8, operand width; square width is 2*WIDTH.

Function
REQ-008 The block SHALL compute N*N by accumulating odd numbers, sq += 2k+1 for k = 0..N-1, with no multiplier.
REQ-009 The block SHALL have three states: IDLE, CALC and DONE.
REQ-010 IDLE -> CALC on an edge with start_i=1: latch N=valor_i, k=0, sq=0.
REQ-011 CALC, k!=N: sq <= sq + {k,1'b1} (9-bit addend, zero-extended to 16), k <= k+1, stay in CALC.
REQ-012 CALC, k==N: square_o <= sq, go to DONE.
REQ-013 DONE SHALL last exactly one cycle with ready_o=1, then return to IDLE unconditionally.
REQ-014 Latency: ready_o SHALL be high in the cycle after rising edge N+1, counting the edge that samples start_i as edge 0 (N=0 -> edge 1; N=255 -> edge 256).
REQ-015 start_i during CALC or DONE SHALL be ignored; valor_i changes after acceptance SHALL NOT affect the result.
REQ-016 start_i in the same cycle that ready_o is high SHALL be ignored; a new start is accepted only in IDLE.
REQ-017 Accumulator and counter widths SHALL be 16 and 9 bits; max result 255*255 = 65025 SHALL NOT overflow.
REQ-018 busy_o SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-019 square_o SHALL update only on the CALC->DONE transition.

Reset
REQ-020 rst=1 at a rising edge SHALL force IDLE, k=0, sq=0, square_o=0, ready_o=0, busy_o=0, regardless of state.
REQ-021 Reset mid-CALC SHALL abort the operation: no ready_o pulse, and square_o=0.
REQ-022 start_i SHALL be ignored on any edge where rst=1.

Structure
REQ-023 The shared package squarer_pkg SHALL define the state enum (IDLE, CALC, DONE), WIDTH and SQ_WIDTH=2*WIDTH.
REQ-024 The accumulate step SHALL be a sub-module, square_step_adder (16-bit A + 16-bit B, no carry-in, carry-out unused).
REQ-025 FSM, counter and registers SHALL stay in square_seq; all outputs SHALL be registered.

Verification
REQ-026 start with N=0 -> ready_o at edge 1, square_o=0x0000.
REQ-027 start with N=12 -> ready_o at edge 13, square_o=144 (0x0090); busy_o high from edge 0 through the ready cycle.
REQ-028 start with N=255 -> ready_o at edge 256, square_o=65025 (0xFE01).
REQ-029 start with N=5, a second start with N=9 at edge 3, and valor_i changed to 9 at edge 2 -> one ready_o pulse only, square_o=25.
REQ-030 start with N=200, rst pulsed at edge 50 -> IDLE, no ready_o, square_o=0; next start with N=3 -> square_o=9 at edge 4.
REQ-031 Back-to-back runs N=7 then N=16, with the second start issued the cycle after ready_o -> square_o=49 then 256, and square_o=49 held in between.
